dsp_stream_feeder: RTL and testbench

Initiator-side companion for the DSP pipeline. It takes an upstream valid/ready sample stream, buffers it in a FIFO, and issues one sample at a time into the pipeline's data_in/data_valid_in port, but only when pipeline_ready is high. It captures the single resulting data_out/data_valid_out beat and presents it on a downstream valid/ready stream. A timeout, error state and counters cover lost results.

---
 rtl/dsp_stream_feeder.sv | 214 +++++++++++++++++++++
 tb/tb_dsp_stream_feeder.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_stream_feeder.sv
// Feeds buffered upstream samples into the DSP pipeline one at a time and
// returns each captured result on a downstream valid/ready stream.
module dsp_stream_feeder #(
    parameter int DATA_WIDTH     = 32,
    parameter int FIFO_DEPTH     = 16,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        clear_error,
    input  logic [DATA_WIDTH-1:0]       s_data,
    input  logic                        s_valid,
    output logic                        s_ready,
    output logic [DATA_WIDTH-1:0]       pipe_data,
    output logic                        pipe_valid,
    input  logic                        pipe_ready,
    input  logic [DATA_WIDTH-1:0]       pipe_result,
    input  logic                        pipe_result_valid,
    output logic [DATA_WIDTH-1:0]       m_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic                        busy,
    output logic                        error,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic [31:0]                 issued_count,
    output logic [31:0]                 completed_count,
    output logic [15:0]                 timeout_count,
    output logic [15:0]                 spurious_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] WAIT_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]           level_q, level_d;
    logic [DATA_WIDTH-1:0] pipe_data_q, pipe_data_d, m_data_q, m_data_d;
    logic                  pipe_valid_q, pipe_valid_d, m_valid_q, m_valid_d;
    logic                  error_q, error_d;
    logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
    logic [31:0]           issued_q, issued_d, completed_q, completed_d;
    logic [15:0]           timeout_q, timeout_d, spurious_q, spurious_d;
    logic                  push_s, pop_s, empty_s, full_s;

    assign empty_s = (level_q == '0);
    assign full_s  = (level_q == LEVEL_FULL);
    assign push_s  = s_valid && !full_s;

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // FIFO storage write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= s_data;
        end
    end

    // Transaction FSM next-state, output and counter logic
    always_comb begin
        state_d      = state_q;
        pipe_data_d  = pipe_data_q;
        pipe_valid_d = 1'b0;
        m_data_d     = m_data_q;
        m_valid_d    = m_valid_q;
        error_d      = error_q;
        wait_cnt_d   = wait_cnt_q;
        issued_d     = issued_q;
        completed_d  = completed_q;
        timeout_d    = timeout_q;
        pop_s        = 1'b0;

        // A result beat is only meaningful while a sample is in flight.
        if (pipe_result_valid && (state_q != ST_WAIT)) begin
            spurious_d = spurious_q + 16'd1;
        end else begin
            spurious_d = spurious_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (enable && !empty_s && pipe_ready) begin
                    pop_s        = 1'b1;
                    pipe_data_d  = mem_q[rd_ptr_q];
                    pipe_valid_d = 1'b1;
                    state_d      = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                issued_d   = issued_q + 32'd1;
                wait_cnt_d = '0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                if (pipe_result_valid) begin
                    m_data_d  = pipe_result;
                    m_valid_d = 1'b1;
                    state_d   = ST_HOLD;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d = timeout_q + 16'd1;
                    error_d   = 1'b1;
                    state_d   = ST_ERROR;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            ST_HOLD: begin
                if (m_ready) begin
                    completed_d = completed_q + 32'd1;
                    m_valid_d   = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            ST_ERROR: begin
                if (clear_error) begin
                    error_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ERROR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, FIFO control and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            pipe_data_q  <= '0;
            pipe_valid_q <= 1'b0;
            m_data_q     <= '0;
            m_valid_q    <= 1'b0;
            error_q      <= 1'b0;
            wait_cnt_q   <= '0;
            issued_q     <= 32'd0;
            completed_q  <= 32'd0;
            timeout_q    <= 16'd0;
            spurious_q   <= 16'd0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            pipe_data_q  <= pipe_data_d;
            pipe_valid_q <= pipe_valid_d;
            m_data_q     <= m_data_d;
            m_valid_q    <= m_valid_d;
            error_q      <= error_d;
            wait_cnt_q   <= wait_cnt_d;
            issued_q     <= issued_d;
            completed_q  <= completed_d;
            timeout_q    <= timeout_d;
            spurious_q   <= spurious_d;
        end
    end

    assign s_ready         = !full_s;
    assign pipe_data       = pipe_data_q;
    assign pipe_valid      = pipe_valid_q;
    assign m_data          = m_data_q;
    assign m_valid         = m_valid_q;
    assign busy            = (state_q != ST_IDLE);
    assign error           = error_q;
    assign fifo_level      = level_q;
    assign issued_count    = issued_q;
    assign completed_count = completed_q;
    assign timeout_count   = timeout_q;
    assign spurious_count  = spurious_q;

endmodule

// File: tb/tb_dsp_stream_feeder.sv
// Randomized self-checking bench for dsp_stream_feeder with a transaction-level
// reference model (sample queue, in-flight/hold/error flags, latency countdowns).
module tb_dsp_stream_feeder;
    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int T     = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable, clear_error;
    logic [DW-1:0] s_data;
    logic          s_valid, s_ready;
    logic [DW-1:0] pipe_data;
    logic          pipe_valid, pipe_ready;
    logic [DW-1:0] pipe_result;
    logic          pipe_result_valid;
    logic [DW-1:0] m_data;
    logic          m_valid, m_ready;
    logic          busy, error;
    logic [4:0]    fifo_level;
    logic [31:0]   issued_count, completed_count;
    logic [15:0]   timeout_count, spurious_count;

    dsp_stream_feeder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear_error(clear_error),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .pipe_data(pipe_data), .pipe_valid(pipe_valid), .pipe_ready(pipe_ready),
        .pipe_result(pipe_result), .pipe_result_valid(pipe_result_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .error(error), .fifo_level(fifo_level),
        .issued_count(issued_count), .completed_count(completed_count),
        .timeout_count(timeout_count), .spurious_count(spurious_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cycle   = 0;

    logic [31:0] exp_fifo[$];
    int          lat_q[$];
    bit          inflight, holding, in_error, resp_live, spur_live, spur_req, rand_lat;
    int          resp_cd, to_cd, last_issue, min_gap;
    logic [31:0] exp_m, last_m_obs;
    logic [31:0] exp_issued, exp_completed;
    logic [15:0] exp_timeout, exp_spur;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, expv);
        end
    endtask

    function automatic logic [31:0] result_of(input logic [31:0] d);
        return {d[15:0], d[31:16]} ^ 32'hBBBB1110;
    endfunction

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0)      return 0;
        else if (r < 3)  return 1;
        else if (r < 7)  return 5;
        else             return int'($urandom_range(1, T));
    endfunction

    task automatic model_reset();
        exp_fifo.delete();
        lat_q.delete();
        inflight = 0; holding = 0; in_error = 0;
        resp_live = 0; spur_live = 0; spur_req = 0;
        resp_cd = 0; to_cd = 0; last_issue = -1; min_gap = 1000000;
        exp_m = '0; last_m_obs = '0;
        exp_issued = '0; exp_completed = '0; exp_timeout = '0; exp_spur = '0;
        pipe_result_valid = 1'b0;
    endtask

    // One clock: snapshot handshakes before the edge, advance the model, drive the
    // pipeline stub, then compare every visible output against the model.
    task automatic step();
        bit          pre_push, pre_issue, pre_hs, pre_clr, pre_resp, pre_spur;
        logic [31:0] pre_sdata, pre_mdata, d;
        int          lat;
        pre_push  = rst_n && s_valid && (exp_fifo.size() < DEPTH);
        pre_sdata = s_data;
        pre_issue = rst_n && !inflight && !in_error && enable && pipe_ready && (exp_fifo.size() > 0);
        pre_hs    = holding && m_ready;
        pre_mdata = m_data;
        pre_clr   = in_error && clear_error;
        pre_resp  = resp_live;
        pre_spur  = spur_live;
        @(posedge clk);
        #1;
        cycle++;
        d = '0;
        if (pre_hs) begin
            holding = 0; inflight = 0; exp_completed++; last_m_obs = pre_mdata;
        end
        if (pre_clr)  in_error = 0;
        if (pre_resp) holding = 1;
        if (pre_spur) exp_spur++;
        if (to_cd > 0) begin
            to_cd--;
            if (to_cd == 0) begin
                inflight = 0; in_error = 1; exp_timeout++;
            end
        end
        resp_live = 0; spur_live = 0;
        pipe_result_valid = 1'b0;
        pipe_result = $urandom();
        if (resp_cd > 0) begin
            resp_cd--;
            if (resp_cd == 0) begin
                pipe_result_valid = 1'b1; pipe_result = exp_m; resp_live = 1;
            end
        end else if (spur_req) begin
            pipe_result_valid = 1'b1; spur_live = 1; spur_req = 0;
        end
        if (pre_push) exp_fifo.push_back(pre_sdata);
        if (pre_issue) begin
            d = exp_fifo.pop_front();
            inflight = 1; exp_issued++;
            exp_m = result_of(d);
            if (lat_q.size() > 0) lat = lat_q.pop_front();
            else if (rand_lat)    lat = pick_lat();
            else                  lat = 5;
            if (lat == 0) to_cd = T + 1;
            else          resp_cd = lat;
            if (last_issue >= 0 && (cycle - last_issue) < min_gap) min_gap = cycle - last_issue;
            last_issue = cycle;
        end
        check_eq("pipe_valid", pipe_valid, pre_issue);
        if (pre_issue) check_eq("pipe_data", pipe_data, d);
        check_eq("m_valid", m_valid, holding);
        if (holding) check_eq("m_data", m_data, exp_m);
        check_eq("error", error, in_error);
        check_eq("busy", busy, inflight || in_error);
        check_eq("fifo_level", fifo_level, exp_fifo.size());
        check_eq("s_ready", s_ready, exp_fifo.size() != DEPTH);
    endtask

    task automatic check_counters(input string tag);
        check_eq({tag, "_issued"}, issued_count, exp_issued);
        check_eq({tag, "_completed"}, completed_count, exp_completed);
        check_eq({tag, "_timeouts"}, timeout_count, exp_timeout);
        check_eq({tag, "_spurious"}, spurious_count, exp_spur);
    endtask

    task automatic push_one(input logic [31:0] dval);
        bit acc;
        acc = 0;
        s_valid = 1'b1; s_data = dval;
        for (int i = 0; i < 200 && !acc; i++) begin
            acc = (exp_fifo.size() < DEPTH);
            step();
        end
        s_valid = 1'b0;
        check_eq("push_accept", acc, 1);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done;
        done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            clear_error = in_error && !clear_error;
            step();
            done = (exp_fifo.size() == 0) && !inflight && !in_error;
        end
        clear_error = 1'b0;
        check_eq(tag, done, 1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit ok;
        rst_n = 1'b0; enable = 1'b0; clear_error = 1'b0;
        s_data = '0; s_valid = 1'b0; pipe_ready = 1'b0; m_ready = 1'b0;
        pipe_result = '0; rand_lat = 0;
        model_reset();
        repeat (2) step();
        check_eq("rst_s_ready", s_ready, 1);
        check_eq("rst_pipe_data", pipe_data, 0);
        check_eq("rst_m_data", m_data, 0);
        check_counters("rst");
        rst_n = 1'b1;
        step();

        // Normal flow
        enable = 1'b1; pipe_ready = 1'b1; m_ready = 1'b1;
        lat_q.push_back(5);
        push_one(32'h11111111);
        wait_idle("t1_drain", 50);
        check_eq("t1_result", last_m_obs, 32'hAAAA0001);
        check_counters("t1");

        // FIFO full / backpressure, then in-order drain
        enable = 1'b0; s_valid = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            s_data = $urandom();
            step();
        end
        s_data = $urandom();
        repeat (3) step();
        check_eq("t2_level_full", fifo_level, DEPTH);
        check_eq("t2_s_ready_low", s_ready, 0);
        last_issue = -1; min_gap = 1000000;
        enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            ok = (exp_fifo.size() < DEPTH);
            step();
        end
        s_valid = 1'b0;
        check_eq("t2_17th_accept", ok, 1);
        wait_idle("t2_drain", 400);
        check_eq("t2_gap_ge8", min_gap >= 8, 1);
        check_counters("t2");

        // Timeout, error hold, clear and resume
        lat_q.push_back(0);
        lat_q.push_back(5);
        push_one($urandom());
        push_one($urandom());
        ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            step();
            ok = in_error;
        end
        check_eq("t3_reach_error", ok, 1);
        repeat (5) step();
        check_counters("t3_err");
        clear_error = 1'b1;
        step();
        clear_error = 1'b0;
        wait_idle("t3_resume", 60);
        check_counters("t3");

        // Downstream stall with a queued sample
        m_ready = 1'b0;
        push_one($urandom());
        push_one($urandom());
        ok = holding;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            ok = holding;
        end
        check_eq("t4_reach_hold", ok, 1);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) spur_req = 1;
            step();
        end
        m_ready = 1'b1;
        wait_idle("t4_drain", 80);
        check_counters("t4");

        // Spurious in IDLE; result on the final WAIT cycle
        spur_req = 1;
        repeat (2) step();
        check_eq("t5_no_mvalid", m_valid, 0);
        check_counters("t5_spur");
        lat_q.push_back(T);
        push_one($urandom());
        wait_idle("t5_last_cycle", 60);
        check_counters("t5");

        // Randomized traffic including bypass latency and timeouts
        rand_lat = 1;
        for (int i = 0; i < 1500; i++) begin
            s_valid     = ($urandom_range(0, 9) < 6);
            s_data      = $urandom();
            enable      = ($urandom_range(0, 9) != 0);
            pipe_ready  = ($urandom_range(0, 9) < 8);
            m_ready     = ($urandom_range(0, 9) < 7);
            clear_error = in_error && ($urandom_range(0, 3) == 0);
            if (resp_cd == 0 && (!inflight || holding) && $urandom_range(0, 19) == 0) spur_req = 1;
            step();
        end
        s_valid = 1'b0; enable = 1'b1; pipe_ready = 1'b1; m_ready = 1'b1; clear_error = 1'b0;
        rand_lat = 0;
        wait_idle("rand_drain", 3000);
        check_counters("rand");

        // Asynchronous reset during WAIT with three samples queued
        enable = 1'b0;
        for (int i = 0; i < 4; i++) push_one($urandom());
        enable = 1'b1;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step();
            ok = inflight;
        end
        check_eq("t6_issued", ok, 1);
        repeat (2) step();
        check_eq("t6_level3", fifo_level, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_pipe_valid", pipe_valid, 0);
        check_eq("t6_m_valid", m_valid, 0);
        check_eq("t6_busy", busy, 0);
        check_eq("t6_error", error, 0);
        check_eq("t6_level0", fifo_level, 0);
        check_eq("t6_issued_cnt", issued_count, 0);
        check_eq("t6_pipe_data", pipe_data, 0);
        model_reset();
        enable = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check_eq("t6_s_ready", s_ready, 1);
        enable = 1'b1;
        push_one($urandom());
        wait_idle("t6_recover", 60);
        check_counters("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
